l_stf_gen: RTL and testbench
============================

L_STF_GEN -- requirements
Module: l_stf_gen

Interface
REQ-001 Parameter DATA_W, default 16, signed I and Q output width, legal range 12..24.
REQ-002 Parameter N_PERIOD, default 10, number of 16-sample short-training periods, legal range 1..255.
REQ-003 Parameter WIN_EN, default 1, 1 = edge windowing enabled (REQ-014).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  request one preamble; sampled only in IDLE.
REQ-007 scale_sh  in  3  arithmetic right-shift amount; captured on the accepted start.
REQ-008 o_valid  out  1  o_iq holds a valid sample.
REQ-009 o_ready  in  1  downstream accepts; transfer = o_valid & o_ready.
REQ-010 o_iq  out  2*DATA_W  {I[DATA_W-1:0], Q[DATA_W-1:0]}, two's complement.
REQ-011 o_last  out  1  marks the final sample of the preamble.
REQ-012 busy  out  1  high in RUN and TAIL.
REQ-013 done  out  1  one-cycle pulse after the final transfer.

Function
REQ-014 The block SHALL output N_PERIOD*16 samples. With WIN_EN=1 it SHALL also output one extra tail sample, for a total of N_PERIOD*16+1 samples. With WIN_EN=1, the first sample and the tail sample (both base index 0) SHALL be arithmetic-shifted right by 1 before scaling.
REQ-015 The base table SHALL be internal, 16 entries, signed 16-bit, given as (I,Q) in hex. Entries by index: 0 (02f2,02f2); 1 (03d9,0198); 2 (042a,0000); 3 (03d9,fe68); 4 (02f2,fd0e); 5 (0198,fc27); 6 (0000,fbd6); 7 (fe68,fc27); 8 (fd0e,fd0e); 9 (fc27,fe68); 10 (fbd6,0000); 11 (fc27,0198); 12 (fd0e,02f2); 13 (fe68,03d9); 14 (0000,042a); 15 (0198,03d9).
REQ-016 Width rule: for DATA_W>=16, sign-extend each table value and shift it left by DATA_W-16. For DATA_W<16, arithmetic-shift right by 16-DATA_W (floor, no rounding).
REQ-017 After the width rule and any window halving, apply arithmetic right shift by the captured scale_sh, floor. The result SHALL never saturate.
REQ-018 FSM states SHALL be IDLE, RUN, TAIL and DONE.
  - IDLE->RUN on start=1.
  - RUN->TAIL on the transfer of sample N_PERIOD*16-1 when WIN_EN=1.
  - RUN->DONE on that same transfer when WIN_EN=0.
  - TAIL->DONE on the tail transfer.
  - DONE->IDLE unconditionally after 1 cycle.
REQ-019 Latency: start sampled high at edge n SHALL give o_valid=1 with sample 0 after edge n+1.
REQ-020 The 4-bit sample index SHALL advance only on a transfer and wrap 15->0. The period counter SHALL increment on each wrap.
REQ-021 While o_valid=1 and o_ready=0, o_iq and o_last SHALL hold stable. o_valid SHALL not drop until a transfer occurs.
REQ-022 With o_ready held at 1, one sample SHALL transfer per cycle with no bubbles from the first sample through the last.
REQ-023 o_last SHALL be 1 only on the final sample: index N_PERIOD*16 when WIN_EN=1, else N_PERIOD*16-1.
REQ-024 The cycle after the final transfer, o_valid SHALL be 0 and done SHALL be 1 for exactly one cycle. The block SHALL be in IDLE, able to sample start, one cycle later.
REQ-025 start asserted while busy=1 or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-026 Changes on scale_sh after start is accepted SHALL have no effect until the next accepted start.

Reset
REQ-027 With rstn=0 at a clock edge, the following SHALL hold after that edge:
  - state=IDLE, counters=0, captured scale_sh=0;
  - o_valid=0, o_iq=0, o_last=0, busy=0, done=0.
REQ-028 Reset asserted mid-preamble SHALL abort the preamble: no further samples and no done pulse. A start after reset release SHALL restart from sample 0.

Verification
REQ-029 DATA_W=16, N_PERIOD=10, WIN_EN=1, scale_sh=0, o_ready=1, start pulse:
  - expect 161 consecutive samples;
  - first and tail sample 0179_0179;
  - sample 1 03d9_0198, sample 16 02f2_02f2;
  - o_last only on the tail sample, done pulse 1 cycle after it.
REQ-030 WIN_EN=0, N_PERIOD=2, scale_sh=2: expect 32 samples, sample 2 = 010a_0000, sample 6 = 0000_fef5, o_last on sample 31.
REQ-031 DATA_W=12, scale_sh=0: sample 0 before windowing = 02f_02f; sample 10 = fbd_000.
REQ-032 Random o_ready backpressure, 30% low: the sample sequence SHALL equal the no-backpressure sequence, and o_iq SHALL stay stable during every stall.
REQ-033 Extra start pulses during RUN SHALL be ignored, giving exactly one preamble and one done pulse.
REQ-034 rstn=0 at sample 37 SHALL give o_valid=0 after the next edge and no done pulse. A following start SHALL begin at sample 0 with correct values.

Source files
------------

// File: rtl/l_stf_gen.sv
// l_stf_gen: short-training-field preamble generator with optional edge windowing,
// output scaling and valid/ready backpressure.
module l_stf_gen #(
   parameter int DATA_W   = 16,
   parameter int N_PERIOD = 10,
   parameter int WIN_EN   = 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic [2:0]          scale_sh,
   output logic                o_valid,
   input  logic                o_ready,
   output logic [2*DATA_W-1:0] o_iq,
   output logic                o_last,
   output logic                busy,
   output logic                done
);
   typedef enum logic [1:0] {IDLE, RUN, TAIL, DONE} state_t;
   localparam logic [15:0] TI [16] = '{16'h02f2, 16'h03d9, 16'h042a, 16'h03d9,
                                       16'h02f2, 16'h0198, 16'h0000, 16'hfe68,
                                       16'hfd0e, 16'hfc27, 16'hfbd6, 16'hfc27,
                                       16'hfd0e, 16'hfe68, 16'h0000, 16'h0198};
   localparam logic [15:0] TQ [16] = '{16'h02f2, 16'h0198, 16'h0000, 16'hfe68,
                                       16'hfd0e, 16'hfc27, 16'hfbd6, 16'hfc27,
                                       16'hfd0e, 16'hfe68, 16'h0000, 16'h0198,
                                       16'h02f2, 16'h03d9, 16'h042a, 16'h03d9};
   state_t             st, st_nx;
   logic [3:0]         idx;
   logic [7:0]         per;
   logic [2:0]         sh;
   logic               vld;
   logic               xfer;
   logic               end_run;
   logic               half;
   logic [4:0]         sa;
   logic signed [23:0] wi, wq;
   assign xfer    = vld & o_ready;
   assign end_run = (idx == 4'hf) && (per == 8'(N_PERIOD - 1));
   assign half    = (WIN_EN != 0) && ((st == TAIL) || (idx == 4'h0 && per == 8'h00));
   // Table values sit at bit 8 of a 24-bit word, so one floor shift covers the
   // width rule, the window halving and the scale in a single step.
   assign sa      = 5'(24 - DATA_W) + 5'(half) + 5'(sh);
   assign wi      = $signed({TI[idx], 8'h00}) >>> sa;
   assign wq      = $signed({TQ[idx], 8'h00}) >>> sa;
   assign o_valid = vld;
   assign o_iq    = vld ? {wi[DATA_W-1:0], wq[DATA_W-1:0]} : '0;
   assign o_last  = vld && ((WIN_EN != 0) ? (st == TAIL) : (st == RUN && end_run));
   assign busy    = (st == RUN) || (st == TAIL);
   assign done    = (st == DONE);
   always_comb begin
      st_nx = st;
      case (st)
         IDLE:    st_nx = start ? RUN : IDLE;
         RUN:     if (xfer && end_run) st_nx = (WIN_EN != 0) ? TAIL : DONE;
         TAIL:    st_nx = xfer ? DONE : TAIL;
         default: st_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         st  <= IDLE;
         idx <= '0;
         per <= '0;
         sh  <= '0;
         vld <= 1'b0;
      end else begin
         st  <= st_nx;
         vld <= busy && !(xfer && o_last);
         if (st == IDLE && start) begin
            sh  <= scale_sh;
            idx <= '0;
            per <= '0;
         end else if (st == RUN && xfer) begin
            idx <= idx + 4'd1;
            if (idx == 4'hf) per <= per + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_l_stf_gen.sv
// tb_l_stf_gen: directed checks of the preamble generator in three configurations.
module tb_l_stf_gen;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0, o_ready = 1'b1;
   logic [2:0]  scale_sh = '0;
   logic        o_valid, o_last, busy, done;
   logic [31:0] o_iq;
   logic        start2 = 1'b0, ready2 = 1'b1;
   logic [2:0]  sh2 = '0;
   logic        v2, last2, busy2, done2;
   logic [31:0] iq2;
   logic        start3 = 1'b0, ready3 = 1'b1;
   logic [2:0]  sh3 = '0;
   logic        v3, last3, busy3, done3;
   logic [23:0] iq3;
   int nvec = 0;
   int nerr = 0;
   localparam logic [15:0] TI [16] = '{16'h02f2, 16'h03d9, 16'h042a, 16'h03d9,
                                       16'h02f2, 16'h0198, 16'h0000, 16'hfe68,
                                       16'hfd0e, 16'hfc27, 16'hfbd6, 16'hfc27,
                                       16'hfd0e, 16'hfe68, 16'h0000, 16'h0198};
   localparam logic [15:0] TQ [16] = '{16'h02f2, 16'h0198, 16'h0000, 16'hfe68,
                                       16'hfd0e, 16'hfc27, 16'hfbd6, 16'hfc27,
                                       16'hfd0e, 16'hfe68, 16'h0000, 16'h0198,
                                       16'h02f2, 16'h03d9, 16'h042a, 16'h03d9};
   always #5 clk = ~clk;

   l_stf_gen dut (.clk(clk), .rstn(rstn), .start(start), .scale_sh(scale_sh),
                  .o_valid(o_valid), .o_ready(o_ready), .o_iq(o_iq), .o_last(o_last),
                  .busy(busy), .done(done));
   l_stf_gen #(.DATA_W(16), .N_PERIOD(2), .WIN_EN(0)) dut2 (
                  .clk(clk), .rstn(rstn), .start(start2), .scale_sh(sh2),
                  .o_valid(v2), .o_ready(ready2), .o_iq(iq2), .o_last(last2),
                  .busy(busy2), .done(done2));
   l_stf_gen #(.DATA_W(12), .N_PERIOD(1), .WIN_EN(1)) dut3 (
                  .clk(clk), .rstn(rstn), .start(start3), .scale_sh(sh3),
                  .o_valid(v3), .o_ready(ready3), .o_iq(iq3), .o_last(last3),
                  .busy(busy3), .done(done3));

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: width rule, then window halving, then scale, each a separate floor step.
   function automatic logic [47:0] model(int dw, int n, bit win, int k, int sh);
      int b, i, q;
      logic [47:0] m;
      b = k % 16;
      i = {{16{TI[b][15]}}, TI[b]};
      q = {{16{TQ[b][15]}}, TQ[b]};
      if (dw >= 16) begin
         i = i <<< (dw - 16);
         q = q <<< (dw - 16);
      end else begin
         i = i >>> (16 - dw);
         q = q >>> (16 - dw);
      end
      if (win && (k == 0 || k == n * 16)) begin
         i = i >>> 1;
         q = q >>> 1;
      end
      i = i >>> sh;
      q = q >>> sh;
      m = (48'd1 << dw) - 48'd1;
      return ((48'(i) & m) << dw) | (48'(q) & m);
   endfunction

   task automatic run_main(input int bp, input bit extra, input int abort_at, input logic [2:0] shv);
      int k, ndone, seen;
      bit stalled;
      logic [31:0] piq;
      logic plast;
      k = 0; ndone = 0; seen = 0; stalled = 0; piq = '0; plast = 1'b0;
      scale_sh = shv; start = 1'b1; o_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; scale_sh = ~shv;
      chk("lat_valid0", o_valid, 0);
      chk("busy_run", busy, 1);
      @(negedge clk);
      for (int c = 0; c < 3000 && k < 161; c++) begin
         if (done) ndone++;
         if (bp == 0 || stalled) chk("valid_hold", o_valid, 1);
         if (stalled) begin
            chk("stall_iq", o_iq, piq);
            chk("stall_last", o_last, plast);
         end
         if (o_valid) begin
            chk("iq", o_iq, model(16, 10, 1, k, shv));
            chk("last", o_last, k == 160);
            if (shv == 0 && (k == 0 || k == 160)) chk("win_edge", o_iq, 32'h01790179);
            if (shv == 0 && k == 1) chk("s1", o_iq, 32'h03d90198);
            if (shv == 0 && k == 16) chk("s16", o_iq, 32'h02f202f2);
         end
         if (o_valid && k == abort_at) begin
            rstn = 1'b0;
            @(negedge clk);
            chk("abort_valid", o_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_iq", o_iq, 0);
            chk("abort_last", o_last, 0);
            rstn = 1'b1;
            repeat (6) begin
               @(negedge clk);
               seen += int'(o_valid | done);
            end
            chk("abort_quiet", seen, 0);
            return;
         end
         o_ready = (bp == 0) || ($urandom_range(99) >= bp);
         start = extra && (c % 5 == 2);
         stalled = o_valid && !o_ready;
         piq = o_iq; plast = o_last;
         if (o_valid && o_ready) k++;
         @(negedge clk);
      end
      start = extra;
      chk("run_len", k, 161);
      chk("early_done", ndone, 0);
      chk("end_valid", o_valid, 0);
      chk("done_pulse", done, 1);
      @(negedge clk);
      start = 1'b0;
      chk("done_once", done, 0);
      chk("idle_busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("no_queue", o_valid | busy, 0);
      o_ready = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_valid", o_valid, 0);
      chk("rst_iq", o_iq, 0);
      chk("rst_last", o_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_d2", {v2, iq2, last2, busy2, done2}, 0);
      chk("rst_d3", {v3, iq3, last3, busy3, done3}, 0);
      rstn = 1'b1;
      @(negedge clk);
      run_main(0, 1'b0, -1, 3'd0);
      run_main(30, 1'b0, -1, 3'd0);
      run_main(0, 1'b1, -1, 3'd3);
      run_main(0, 1'b0, 37, 3'd0);
      run_main(0, 1'b0, -1, 3'd0);
      run_main(30, 1'b0, -1, 3'd5);
      sh2 = 3'd2; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0; sh2 = 3'd0;
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
         chk("d2_valid", v2, 1);
         chk("d2_iq", iq2, model(16, 2, 0, k, 2));
         chk("d2_last", last2, k == 31);
         if (k == 2) chk("d2_s2", iq2, 32'h010a0000);
         if (k == 6) chk("d2_s6", iq2, 32'h0000fef5);
         @(negedge clk);
      end
      chk("d2_end_valid", v2, 0);
      chk("d2_done", done2, 1);
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 17; k++) begin
         chk("d3_valid", v3, 1);
         chk("d3_iq", iq3, model(12, 1, 1, k, 0));
         chk("d3_last", last3, k == 16);
         if (k == 0 || k == 16) chk("d3_win", iq3, 24'h017017);
         if (k == 10) chk("d3_s10", iq3, 24'hfbd000);
         @(negedge clk);
      end
      chk("d3_done", done3, 1);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
